// File: rtl/segment_reader_if.sv
// Segment-reader bus: two active-low 7-segment digit inputs plus the
// value report handshake and status flags returned by the reader.
interface segment_reader_if;
  logic [6:0] hex1;
  logic [6:0] hex0;
  logic       value_ready;
  logic [5:0] value;
  logic       value_valid;
  logic       seg_err;
  logic       err_sticky;
  logic       overrun;
  logic [7:0] change_count;

  modport master (
    output hex1, hex0, value_ready,
    input  value, value_valid, seg_err, err_sticky, overrun, change_count
  );

  modport slave (
    input  hex1, hex0, value_ready,
    output value, value_valid, seg_err, err_sticky, overrun, change_count
  );
endinterface

// File: rtl/segment_reader.sv
// Debounces a two-digit 7-segment display, decodes the stable pattern into a
// 6-bit accumulator value and reports each change through a valid/ready port.
module segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  segment_reader_if.slave bus
);

  typedef enum logic {SETTLE, LOCKED} state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] digit;
  } seg_dec_t;

  localparam logic [3:0] LOCK_AT   = 4'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t d;
    d.legal = 1'b1;
    d.blank = 1'b0;
    d.digit = 4'h0;
    case (seg)
      7'h40: d.digit = 4'h0;
      7'h79: d.digit = 4'h1;
      7'h24: d.digit = 4'h2;
      7'h30: d.digit = 4'h3;
      7'h19: d.digit = 4'h4;
      7'h12: d.digit = 4'h5;
      7'h02: d.digit = 4'h6;
      7'h78: d.digit = 4'h7;
      7'h00: d.digit = 4'h8;
      7'h10: d.digit = 4'h9;
      7'h08: d.digit = 4'hA;
      7'h03: d.digit = 4'hB;
      7'h46: d.digit = 4'hC;
      7'h21: d.digit = 4'hD;
      7'h06: d.digit = 4'hE;
      7'h0E: d.digit = 4'hF;
      SEG_BLANK: begin
        d.legal = 1'b0;
        d.blank = 1'b1;
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t     state;
  logic [3:0] cnt;
  logic [6:0] s1_p0;
  logic [6:0] s0_p0;
  logic [5:0] value_r;
  logic       value_valid_r;
  logic       seg_err_r;
  logic       err_sticky_r;
  logic       overrun_r;
  logic [7:0] change_count_r;
  logic [5:0] last_val;
  logic       last_vld;

  seg_dec_t   d1;
  seg_dec_t   d0;
  logic       same_p0;
  logic       lock_now;
  logic       pair_blank;
  logic       pair_illegal;
  logic       err_now;
  logic       report;
  logic [5:0] new_val;

  // Decode stage: everything below looks only at the registered sample pair.
  always_comb begin
    d1           = seg_decode(s1_p0);
    d0           = seg_decode(s0_p0);
    same_p0      = (bus.hex1 == s1_p0) && (bus.hex0 == s0_p0);
    lock_now     = (state == SETTLE) && same_p0 && (cnt == LOCK_AT);
    pair_blank   = d1.blank || d0.blank;
    // Upper digit only carries the two MSBs of the accumulator, so 4..F is bad.
    pair_illegal = !pair_blank && (!d1.legal || !d0.legal || (d1.digit > 4'd3));
    new_val      = {d1.digit[1:0], d0.digit};
    err_now      = lock_now && pair_illegal;
    report       = lock_now && !pair_blank && !pair_illegal &&
                   (!last_vld || (new_val != last_val));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SETTLE;
      cnt            <= 4'd0;
      s1_p0          <= SEG_BLANK;
      s0_p0          <= SEG_BLANK;
      value_r        <= 6'd0;
      value_valid_r  <= 1'b0;
      seg_err_r      <= 1'b0;
      err_sticky_r   <= 1'b0;
      overrun_r      <= 1'b0;
      change_count_r <= 8'd0;
      last_val       <= 6'd0;
      last_vld       <= 1'b0;
    end else begin
      s1_p0     <= bus.hex1;
      s0_p0     <= bus.hex0;
      seg_err_r <= err_now;

      case (state)
        SETTLE: begin
          if (!same_p0) begin
            cnt <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
            if (lock_now) state <= LOCKED;
          end
        end
        LOCKED: begin
          if (!same_p0) begin
            state <= SETTLE;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= SETTLE;
          cnt   <= 4'd0;
        end
      endcase

      if (err_now) err_sticky_r <= 1'b1;

      // A fresh report wins over acceptance at the same edge.
      if (report) begin
        value_r        <= new_val;
        value_valid_r  <= 1'b1;
        change_count_r <= sat_inc(change_count_r);
        last_val       <= new_val;
        last_vld       <= 1'b1;
        if (value_valid_r && !bus.value_ready) overrun_r <= 1'b1;
      end else if (value_valid_r && bus.value_ready) begin
        value_valid_r  <= 1'b0;
      end
    end
  end

  assign bus.value        = value_r;
  assign bus.value_valid  = value_valid_r;
  assign bus.seg_err      = seg_err_r;
  assign bus.err_sticky   = err_sticky_r;
  assign bus.overrun      = overrun_r;
  assign bus.change_count = change_count_r;

endmodule

// File: tb/tb_segment_reader.sv
// Directed bench for segment_reader: settle latency, glitch rejection, overrun,
// illegal/blank patterns, same-edge report/accept, mid-settle reset, saturation.
module tb_segment_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  segment_reader_if bus();

  segment_reader #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic show(input logic [6:0] h1, input logic [6:0] h0);
    bus.hex1 = h1;
    bus.hex0 = h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    show(7'h7F, 7'h7F);
    bus.value_ready = 1'b0;
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int npulse;

    show(7'h7F, 7'h7F);
    bus.value_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_value",  32'(bus.value),        0);
    check("rst_vv",     32'(bus.value_valid),  0);
    check("rst_segerr", 32'(bus.seg_err),      0);
    check("rst_sticky", 32'(bus.err_sticky),   0);
    check("rst_ovr",    32'(bus.overrun),      0);
    check("rst_cc",     32'(bus.change_count), 0);

    // 3 / d -> 0x3D, valid 4 edges after the first sample edge
    show(7'h30, 7'h21);
    tick();
    check("lat_e1", 32'(bus.value_valid), 0);
    ticks(3);
    check("lat_e4", 32'(bus.value_valid), 0);
    tick();
    check("lat_e5_vv",    32'(bus.value_valid),  1);
    check("lat_e5_value", 32'(bus.value),        'h3D);
    check("lat_e5_cc",    32'(bus.change_count), 1);

    // Two-cycle glitch on hex0, then back: nothing observable changes
    show(7'h30, 7'h00);
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 2) show(7'h30, 7'h21);
      tick();
      if (bus.seg_err !== 1'b0 || bus.value_valid !== 1'b1 || bus.value !== 6'h3D) bad++;
    end
    check("glitch_bad", 32'(bad), 0);
    check("glitch_cc",  32'(bus.change_count), 1);

    bus.value_ready = 1'b1;
    tick();
    check("accept_vv", 32'(bus.value_valid), 0);
    bus.value_ready = 1'b0;

    // Overrun: 0x1C unaccepted, then replaced by 0x1F
    do_reset();
    show(7'h79, 7'h46);
    ticks(5);
    check("ovr_first_vv",    32'(bus.value_valid), 1);
    check("ovr_first_value", 32'(bus.value),       'h1C);
    show(7'h79, 7'h0E);
    ticks(4);
    check("ovr_hold_value", 32'(bus.value),   'h1C);
    check("ovr_hold_ovr",   32'(bus.overrun), 0);
    tick();
    check("ovr_value", 32'(bus.value),        'h1F);
    check("ovr_ovr",   32'(bus.overrun),      1);
    check("ovr_vv",    32'(bus.value_valid),  1);
    check("ovr_cc",    32'(bus.change_count), 2);

    bus.value_ready = 1'b1;
    tick();
    bus.value_ready = 1'b0;
    check("ovr_accept_vv", 32'(bus.value_valid), 0);

    // Upper digit 4 is illegal: one-cycle seg_err pulse
    show(7'h19, 7'h40);
    ticks(4);
    check("err_pre", 32'(bus.seg_err), 0);
    tick();
    check("err_pulse",  32'(bus.seg_err),     1);
    check("err_sticky", 32'(bus.err_sticky),  1);
    check("err_vv",     32'(bus.value_valid), 0);
    check("err_value",  32'(bus.value),       'h1F);
    tick();
    check("err_post",        32'(bus.seg_err),    0);
    check("err_sticky_hold", 32'(bus.err_sticky), 1);

    // Blank lower digit: neither error nor report
    show(7'h40, 7'h7F);
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (bus.seg_err !== 1'b0 || bus.value_valid !== 1'b0) bad++;
    end
    check("blank_bad", 32'(bad), 0);
    check("blank_cc",  32'(bus.change_count), 2);

    // Re-display of last reported 0x1F: no report
    show(7'h79, 7'h0E);
    ticks(7);
    check("redisp_vv",    32'(bus.value_valid),  0);
    check("redisp_cc",    32'(bus.change_count), 2);
    check("redisp_value", 32'(bus.value),        'h1F);

    // Report and acceptance at the same edge
    do_reset();
    check("rst2_sticky", 32'(bus.err_sticky), 0);
    check("rst2_ovr",    32'(bus.overrun),    0);
    show(7'h79, 7'h46);
    ticks(5);
    check("same_first_vv", 32'(bus.value_valid), 1);
    show(7'h24, 7'h08);
    ticks(4);
    check("same_hold_value", 32'(bus.value), 'h1C);
    bus.value_ready = 1'b1;
    tick();
    check("same_value", 32'(bus.value),        'h2A);
    check("same_vv",    32'(bus.value_valid),  1);
    check("same_ovr",   32'(bus.overrun),      0);
    check("same_cc",    32'(bus.change_count), 2);
    tick();
    check("same_accept_vv", 32'(bus.value_valid), 0);
    bus.value_ready = 1'b0;

    // Reset at cnt=2 of a settle, pattern kept through reset
    show(7'h24, 7'h10);
    ticks(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_value", 32'(bus.value),        0);
    check("mid_rst_vv",    32'(bus.value_valid),  0);
    check("mid_rst_cc",    32'(bus.change_count), 0);
    check("mid_rst_ovr",   32'(bus.overrun),      0);
    ticks(4);
    check("mid_rst_e4_vv", 32'(bus.value_valid), 0);
    tick();
    check("mid_rst_e5_vv",    32'(bus.value_valid),  1);
    check("mid_rst_e5_value", 32'(bus.value),        'h29);
    check("mid_rst_e5_cc",    32'(bus.change_count), 1);

    // 260 alternating values with value_ready held high
    bus.value_ready = 1'b1;
    bad = 0;
    npulse = 0;
    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) show(7'h30, 7'h21);
      else            show(7'h24, 7'h10);
      for (int k = 0; k < 5; k++) begin
        tick();
        if (bus.value_valid === 1'b1) npulse++;
        if (bus.value_valid !== (k == 4)) bad++;
      end
      if (i == 200) check("sat_cc_mid", 32'(bus.change_count), 202);
    end
    check("sat_pulse_bad", 32'(bad), 0);
    check("sat_pulses",    32'(npulse), 260);
    check("sat_cc",        32'(bus.change_count), 255);
    check("sat_value",     32'(bus.value), 'h29);
    check("sat_ovr",       32'(bus.overrun), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/segment_reader.md
SEGMENT_READER -- requirements
Module: segment_reader

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive-equal-sample count needed to accept a display pattern (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 hex1  input  7  upper-digit segment pattern, active-low, bit0=a ... bit6=g.
REQ-005 hex0  input  7  lower-digit segment pattern, same encoding.
REQ-006 value_ready  input  1  consumer accepts value at a rising edge where value_valid=1 and value_ready=1.
REQ-007 value  output  6  reconstructed accumulator value {hex1 digit[1:0], hex0 digit[3:0]}.
REQ-008 value_valid  output  1  value holds an unaccepted report.
REQ-009 seg_err  output  1  one-cycle pulse: stable pattern was illegal.
REQ-010 err_sticky  output  1  set by any seg_err; cleared only by reset.
REQ-011 overrun  output  1  sticky; a report replaced an unaccepted report.
REQ-012 change_count  output  8  number of reports since reset, saturating.

Function
REQ-013 Legal digit patterns SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit); blank=7F.
REQ-014 Both inputs SHALL be registered every edge into a sample pair s1/s0; all decoding uses the registered pair.
REQ-015 Stability counter cnt (4 bits): increments when incoming pair equals s1/s0, clears to 0 otherwise.
REQ-016 FSM states SETTLE and LOCKED; reset enters SETTLE.
REQ-017 SETTLE -> LOCKED at the edge where cnt would reach STABLE_CYCLES; cnt stops counting in LOCKED.
REQ-018 LOCKED -> SETTLE, cnt=0, at any edge where incoming pair differs from s1/s0.
REQ-019 On entering LOCKED: if either digit is blank, no report and no error.
REQ-020 On entering LOCKED: if either digit is not in the table, or hex1 decodes to 4..F, seg_err SHALL pulse for exactly one cycle, err_sticky set, value/value_valid unchanged.
REQ-021 On entering LOCKED with a legal pair whose decoded value differs from last reported value, or first report since reset: a report SHALL occur.
REQ-022 A report loads value, sets value_valid, increments change_count (holds at 255).
REQ-023 Latency: pattern held from before edge N, differing from prior sample; value_valid high after edge N+STABLE_CYCLES.
REQ-024 value_valid SHALL remain high, value stable, until accepted; acceptance clears value_valid at that edge.
REQ-025 Report and acceptance at the same edge: new value loaded, value_valid stays 1, overrun unchanged.
REQ-026 Report while value_valid=1 and value_ready=0: value replaced, value_valid stays 1, overrun set.
REQ-027 A glitch shorter than STABLE_CYCLES+1 edges SHALL produce no report and no error; returning to the locked pattern re-locks without report (value unchanged).
REQ-028 Re-display of the same legal value after a blank or illegal interval SHALL NOT generate a report.

Reset
REQ-029 At a reset edge: s1/s0=7F, cnt=0, state=SETTLE, value=0, value_valid=0, seg_err=0, err_sticky=0, overrun=0, change_count=0, last-reported marker cleared.
REQ-030 Reset mid-settle or with an unaccepted report SHALL discard all pending state; reset overrides every other event at the same edge.

Verification
REQ-031 Reset, then hex1=30 hex0=21 held, value_ready=0 -> value_valid rises 4 edges after first sample edge, value=0x3D, change_count=1.
REQ-032 Locked 0x3D, hex0 glitches to 00 for 2 cycles then back -> no value_valid change, no seg_err, change_count=1.
REQ-033 hex1=79 hex0=46 (0x1C) held, value_ready=0, then hex0=0E held -> value=0x1F, overrun=1, value_valid=1, change_count=2.
REQ-034 hex1=19 (digit 4) held with hex0=40 -> seg_err one-cycle pulse, err_sticky=1, value unchanged; also hex0=7F with hex1=40 -> no pulse.
REQ-035 value_ready=1 throughout, 260 alternating legal values -> each value_valid high one cycle, change_count saturates at 255.
REQ-036 reset asserted at cnt=2 of a settle -> all outputs zero next cycle; held pattern then reports STABLE_CYCLES+1 edges after reset release.
